regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port successor to the single-write, dual-read CPU register file.
- Provides NUM_RD combinational read ports, NUM_WR write ports with fixed priority, optional same-cycle write-to-read bypass, and a per-register pending-write scoreboard for hazard detection.
- A sequenced clear after reset zeroes every entry, so the storage can map to RAM-style arrays without a bulk reset.
- Sits between decode/issue (reads, scoreboard set) and writeback (writes, scoreboard clear) in the pipelined core.

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2: number of read ports.
- NUM_WR, 2: number of write ports.
- BYPASS, 1: 1 forwards same-cycle write data and scoreboard clears to reads; 0 disables forwarding.
- ZERO_REG, 1: 1 hardwires entry 0 to zero and never busy.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  synchronous reset, active-high.
- wr_en_i  in  NUM_WR  per-port write enable.
- wr_addr_i  in  NUM_WR x ADDR_W  write addresses.
- wr_data_i  in  NUM_WR x DATA_W  write data.
- rd_addr_i  in  NUM_RD x ADDR_W  read addresses.
- rd_data_o  out  NUM_RD x DATA_W  read data, combinational.
- busy_o  out  NUM_RD  pending-write status of each read address.
- sb_set_en_i  in  1  mark sb_set_addr_i as having a write pending (issue).
- sb_set_addr_i  in  ADDR_W  scoreboard set address.
- ready_o  out  1  high once the clear sequence has completed.

Behaviour:
- Clock/reset (already decided): one clock, clk_i; reset rst_i is synchronous and active-high.
- FSM states CLEAR and RUN.
  - rst_i high: next state CLEAR, clear counter := 0, all scoreboard bits := 0.
  - CLEAR: each cycle writes 0 to entry[counter] and increments the counter. After writing entry DEPTH-1, go to RUN.
  - ready_o rises on the first RUN cycle, exactly DEPTH cycles after rst_i deasserts.
- During CLEAR:
  - ready_o=0, rd_data_o=0, busy_o=0.
  - wr_en_i and sb_set_en_i are ignored.
- rst_i asserted mid-CLEAR or in RUN restarts the clear from entry 0.
- Reset values of outputs: ready_o=0, rd_data_o=0, busy_o=0.
- Writes (RUN only):
  - Committed on the clock edge; visible through storage on the next cycle.
  - Several enabled ports hitting the same address: the highest-index port wins.
- Reads are combinational from storage.
  - BYPASS=1: if any enabled write port targets rd_addr_i this cycle, return that port's wr_data_i, using the same winner rule.
  - BYPASS=0: return the stored value, which is the old value on a same-cycle write.
- ZERO_REG=1:
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0, including under bypass.
  - sb_set to address 0 is ignored; busy_o for address 0 is always 0.
- Scoreboard, one bit per entry:
  - sb_set_en_i sets bit[sb_set_addr_i].
  - Any enabled write port clears bit[wr_addr_i].
  - Set and clear of the same address in the same cycle: set wins, bit=1.
  - busy_o[i] = bit[rd_addr_i[i]]. With BYPASS=1, a same-cycle clear by a write to that address forces busy_o[i]=0; a same-cycle set does not raise busy_o until the next cycle.
- Widths: no arithmetic on data. The clear counter is ADDR_W+1 bits so DEPTH is representable.

Decomposition:
- Package regfile_pkg:
  - rf_state_e enum {CLEAR, RUN}.
  - Default width/depth/port-count constants.
  - Typedefs for the address and data vectors.
- One sub-module, regfile_fwd: write-port priority resolution plus the bypass/zero mux for a single read port, instantiated NUM_RD times.

Test Plan:
- Reset sequence: rst_i high 1 cycle, then low -> ready_o=0 for 32 cycles then 1; every address reads 0x00000000; all busy_o=0.
- Write then read: write 0xDEADBEEF to r5 via port 0 -> with BYPASS=1, rd_data_o[0]=0xDEADBEEF in the same cycle; with BYPASS=0, old value that cycle and 0xDEADBEEF from the next cycle.
- Write conflict: port0 writes r7=0x11 and port1 writes r7=0x22 in the same cycle -> r7 reads 0x22.
- r0 protection: write 0xFFFFFFFF to r0 and sb_set r0 -> reads 0, busy_o=0.
- Scoreboard: sb_set r9 -> busy_o=1 next cycle. Then sb_set r9 together with a write to r9 -> bit stays 1. Then a write to r9 alone -> busy_o=0 in the same cycle with BYPASS=1, and 0 from the next cycle with BYPASS=0.
- Reset mid-clear: rst_i asserted at clear counter=10 -> clear restarts; ready_o rises 32 cycles after the final rst_i deassertion, and writes issued during CLEAR are ignored.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_DEPTH  = 2 ** RF_ADDR_W;
    localparam int RF_NUM_RD = 2;
    localparam int RF_NUM_WR = 2;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/regfile_fwd.sv
// One read port: write-port priority resolution, optional bypass, zero-register and CLEAR masking.
module regfile_fwd
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_WR   = RF_NUM_WR,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                           run,
    input  logic [NUM_WR-1:0]              wr_en,
    input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr,
    input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data,
    input  logic [ADDR_W-1:0]              rd_addr,
    input  logic [DATA_W-1:0]              mem_data,
    input  logic                           mem_busy,
    output logic [DATA_W-1:0]              rd_data,
    output logic                           busy
);

    logic              hit_s;
    logic [DATA_W-1:0] hit_data_s;

    // Scan ports low to high so the highest-index matching port wins.
    always_comb begin
        hit_s      = 1'b0;
        hit_data_s = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p] && (wr_addr[p] == rd_addr)) begin
                hit_s      = 1'b1;
                hit_data_s = wr_data[p];
            end else begin
                hit_s      = hit_s;
                hit_data_s = hit_data_s;
            end
        end
    end

    // A forwarded write also carries its scoreboard clear, so busy drops with it.
    always_comb begin
        if (!run) begin
            rd_data = '0;
            busy    = 1'b0;
        end else if (ZERO_REG && (rd_addr == '0)) begin
            rd_data = '0;
            busy    = 1'b0;
        end else if (BYPASS && hit_s) begin
            rd_data = hit_data_s;
            busy    = 1'b0;
        end else begin
            rd_data = mem_data;
            busy    = mem_busy;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with sequenced clear, prioritised writes and a pending-write scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = RF_NUM_RD,
    parameter int NUM_WR   = RF_NUM_WR,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_WR-1:0]              wr_en_i,
    input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr_i,
    input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data_i,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr_i,
    output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data_o,
    output logic [NUM_RD-1:0]              busy_o,
    input  logic                           sb_set_en_i,
    input  logic [ADDR_W-1:0]              sb_set_addr_i,
    output logic                           ready_o
);

    localparam int            DEPTH    = 2 ** ADDR_W;
    localparam logic [0:0]    ST_CLEAR = CLEAR;
    localparam logic [0:0]    ST_RUN   = RUN;
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

    logic [0:0]        state_r;
    logic [ADDR_W:0]   clr_cnt_r;
    logic [DEPTH-1:0]  sb_r;
    logic [DEPTH-1:0]  sb_nxt_s;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic              run_s;
    logic              sb_set_ok_s;
    logic [NUM_WR-1:0] wr_en_s;

    assign run_s   = (state_r == ST_RUN);
    assign ready_o = run_s;

    // Effective write enables: RUN only, and address 0 dropped when hardwired.
    always_comb begin
        for (int p = 0; p < NUM_WR; p++) begin
            wr_en_s[p] = run_s && wr_en_i[p] && !(ZERO_REG && (wr_addr_i[p] == '0));
        end
        sb_set_ok_s = run_s && sb_set_en_i && !(ZERO_REG && (sb_set_addr_i == '0));
    end

    // Scoreboard next state: write clears first, then issue set so set wins.
    always_comb begin
        sb_nxt_s = sb_r;
        if (run_s) begin
            for (int p = 0; p < NUM_WR; p++) begin
                sb_nxt_s[wr_addr_i[p]] = wr_en_s[p] ? 1'b0 : sb_nxt_s[wr_addr_i[p]];
            end
            sb_nxt_s[sb_set_addr_i] = sb_set_ok_s ? 1'b1 : sb_nxt_s[sb_set_addr_i];
        end else begin
            sb_nxt_s = sb_r;
        end
    end

    // Control FSM: clear counter, state and scoreboard.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= ST_CLEAR;
            clr_cnt_r <= '0;
            sb_r      <= '0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    clr_cnt_r <= clr_cnt_r + {{ADDR_W{1'b0}}, 1'b1};
                    if (clr_cnt_r == LAST_IDX) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN:   state_r <= ST_RUN;
                default:  state_r <= ST_CLEAR;
            endcase
            sb_r <= sb_nxt_s;
        end
    end

    // Storage has no bulk reset; later ports overwrite earlier ones on the same address.
    always_ff @(posedge clk_i) begin
        if (!rst_i && (state_r == ST_CLEAR)) begin
            mem_r[clr_cnt_r[ADDR_W-1:0]] <= '0;
        end else if (!rst_i) begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_en_s[p]) begin
                    mem_r[wr_addr_i[p]] <= wr_data_i[p];
                end
            end
        end
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        regfile_fwd #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NUM_WR   (NUM_WR),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_fwd (
            .run      (run_s),
            .wr_en    (wr_en_s),
            .wr_addr  (wr_addr_i),
            .wr_data  (wr_data_i),
            .rd_addr  (rd_addr_i[r]),
            .mem_data (mem_r[rd_addr_i[r]]),
            .mem_busy (sb_r[rd_addr_i[r]]),
            .rd_data  (rd_data_o[r]),
            .busy     (busy_o[r])
        );
    end

endmodule
